// File: rtl/display_scan_mux_pkg.sv
// display_pkg: shared definitions for the seven-segment scan multiplexer.
// Provides:
//   nibble_t : 4-bit digit value
//   AN_OFF   : all anodes released (active-low); slice to the bank width
//   DP_OFF   : decimal point dark (active-low)
//   clog2()  : ceiling log2 with a floor of 1, for counter and index widths
package display_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [15:0] AN_OFF = 16'hFFFF;
  localparam logic        DP_OFF = 1'b1;

  // Width helper: a counter of 'value' states needs at least one bit, even
  // when value is 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// display_scan_mux_if: bundle between game logic (master) and the scan
// multiplexer (slave).
//   digits_in   : 4*N_DIGITS nibbles, digit 0 in bits [3:0] (rightmost)
//   digit_en    : 1 = digit may light
//   blink_mask  : 1 = digit blinks
//   dp_in       : 1 = decimal point lit
//   AN          : anode enables, active-low, at most one low
//   dig_out     : nibble of the lit digit
//   dp_out      : decimal point, active-low
//   frame_start : one-cycle pulse when a new input snapshot is taken
interface display_scan_mux_if
  import display_pkg::*;
#(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   AN;
  nibble_t               dig_out;
  logic                  dp_out;
  logic                  frame_start;

  modport master (
    output digits_in, digit_en, blink_mask, dp_in,
    input  AN, dig_out, dp_out, frame_start
  );

  modport slave (
    input  digits_in, digit_en, blink_mask, dp_in,
    output AN, dig_out, dp_out, frame_start
  );
endinterface

// File: rtl/display_scan_mux_prescaler.sv
// scan_prescaler: divides refresh_clock into slot ticks.
//   refresh_clock : clock
//   reset         : synchronous, active-high
//   tick          : high for one cycle every PRESCALE cycles
// Kept generic so LED-matrix scanners can reuse it.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic refresh_clock,
  input  logic reset,
  output logic tick
);
  localparam int W = clog2(PRESCALE);

  logic [W-1:0] pre_cnt_q;
  logic [W-1:0] pre_cnt_d;

  assign tick      = (pre_cnt_q == W'(PRESCALE - 1));
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

  always_ff @(posedge refresh_clock) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end
endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed driver for common-anode 7-seg banks.
//   refresh_clock : clock, all logic on the rising edge
//   reset         : synchronous, active-high
//   bus           : display_scan_mux_if.slave (digit inputs in, AN/dig/dp out)
// Inputs are latched into shadow registers only on the frame wrap, so a frame
// is always drawn from one coherent snapshot. Outputs are registered.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens the run of zero digits
// from the most significant end (stopping at a nonzero digit or a lit dp);
// digit 0 always stays visible.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int PRESCALE     = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               refresh_clock,
  input  logic               reset,
  display_scan_mux_if.slave  bus
);
  localparam int IDX_W = clog2(N_DIGITS);
  localparam int FC_W  = clog2(BLINK_FRAMES);

  logic               tick;
  logic               wrap;
  logic [IDX_W-1:0]   idx_q;
  logic [FC_W-1:0]    frame_cnt_q;
  logic               blink_phase_q;

  nibble_t            shadow_dig_q [N_DIGITS];
  logic [N_DIGITS-1:0] shadow_en_q;
  logic [N_DIGITS-1:0] shadow_blink_q;
  logic [N_DIGITS-1:0] shadow_dp_q;

  logic [N_DIGITS-1:0] lz_blank;
  logic                vis;

  logic [N_DIGITS-1:0] an_q, an_d;
  nibble_t             dig_q, dig_d;
  logic                dp_q, dp_d;
  logic                frame_start_q;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .refresh_clock (refresh_clock),
    .reset         (reset),
    .tick          (tick)
  );

  assign wrap = tick && (idx_q == IDX_W'(N_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;
  // Walk down from the most significant digit while the run of blank zeros
  // continues; a lit dp counts as content and ends the run.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (lz_run && (shadow_dig_q[k] == 4'h0) && !shadow_dp_q[k]) lz_blank[k] = 1'b1;
      else lz_run = 1'b0;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    vis   = shadow_en_q[idx_q] & ~(blink_phase_q & shadow_blink_q[idx_q]) & ~lz_blank[idx_q];
    an_d  = AN_OFF[N_DIGITS-1:0];
    dig_d = 4'h0;
    dp_d  = DP_OFF;
    if (vis) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      dig_d = shadow_dig_q[idx_q];
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge refresh_clock) begin
    if (reset) begin
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_en_q    <= '0;
      shadow_blink_q <= '0;
      shadow_dp_q    <= '0;
      for (int k = 0; k < N_DIGITS; k++) shadow_dig_q[k] <= 4'h0;
      an_q           <= AN_OFF[N_DIGITS-1:0];
      dig_q          <= 4'h0;
      dp_q           <= DP_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;
      if (wrap) begin
        shadow_en_q    <= bus.digit_en;
        shadow_blink_q <= bus.blink_mask;
        shadow_dp_q    <= bus.dp_in;
        for (int k = 0; k < N_DIGITS; k++) shadow_dig_q[k] <= bus.digits_in[4*k +: 4];
        if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
      an_q          <= an_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
      frame_start_q <= wrap;
    end
  end

  assign bus.AN          = an_q;
  assign bus.dig_out     = dig_q;
  assign bus.dp_out      = dp_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: two instances (4 digits / prescale 2 / blink 2,
// and 6 digits / prescale 3 / blink 1). A reference model derives every
// expected output from the number of cycles since reset release using plain
// arithmetic; expectations are queued and a monitor compares each cycle.
module tb_display_scan_mux;
  typedef struct {
    int          cyc;
    logic [15:0] an;
    logic [3:0]  dig;
    logic        dp;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int total = 0;
  int bad   = 0;

  int NU [2] = '{4, 6};
  int PU [2] = '{2, 3};
  int BU [2] = '{2, 1};

  logic [1:0]  rst_v;
  logic [63:0] dig_v  [2];
  logic [15:0] en_v   [2];
  logic [15:0] bl_v   [2];
  logic [15:0] dp_v   [2];

  logic [63:0] sh_dig [2];
  logic [15:0] sh_en  [2];
  logic [15:0] sh_bl  [2];
  logic [15:0] sh_dp  [2];
  int          c_m    [2];

  exp_t q0[$];
  exp_t q1[$];

  display_scan_mux_if #(.N_DIGITS(4)) if0 ();
  display_scan_mux_if #(.N_DIGITS(6)) if1 ();

  assign if0.digits_in  = dig_v[0][15:0];
  assign if0.digit_en   = en_v[0][3:0];
  assign if0.blink_mask = bl_v[0][3:0];
  assign if0.dp_in      = dp_v[0][3:0];
  assign if1.digits_in  = dig_v[1][23:0];
  assign if1.digit_en   = en_v[1][5:0];
  assign if1.blink_mask = bl_v[1][5:0];
  assign if1.dp_in      = dp_v[1][5:0];

  display_scan_mux #(.N_DIGITS(4), .PRESCALE(2), .BLINK_FRAMES(2)) dut0 (
    .refresh_clock (clk),
    .reset         (rst_v[0]),
    .bus           (if0)
  );

  display_scan_mux #(.N_DIGITS(6), .PRESCALE(3), .BLINK_FRAMES(1)) dut1 (
    .refresh_clock (clk),
    .reset         (rst_v[1]),
    .bus           (if1)
  );

  // Digits above the most significant "content" digit (nonzero or dp lit)
  // are blanked; digit 0 never is.
  function automatic logic [15:0] lz_of(int n, logic [63:0] d, logic [15:0] dp);
    logic [15:0] r;
    int top;
    r = '0;
`ifdef LEADING_ZERO_BLANK_EN
    top = 0;
    for (int k = 0; k < n; k++) if (d[4*k +: 4] != 4'h0 || dp[k]) top = k;
    for (int k = 1; k < n; k++) if (k > top) r[k] = 1'b1;
`else
    top = n;
    if (top < 0) r = '1;
`endif
    return r;
  endfunction

  // Expected output for the cycle after the current one, from the current
  // cycle's position in the scan.
  task automatic model_step(int u);
    exp_t e;
    int n, p, idx, frames, phase;
    logic [15:0] mask, lz;
    logic vis;
    n    = NU[u];
    p    = PU[u];
    mask = (16'd1 << n) - 16'd1;
    e.cyc = tcyc + 1;
    e.an  = mask;
    e.dig = 4'h0;
    e.dp  = 1'b1;
    e.fs  = 1'b0;
    if (rst_v[u]) begin
      c_m[u]    = -1;
      sh_dig[u] = '0;
      sh_en[u]  = '0;
      sh_bl[u]  = '0;
      sh_dp[u]  = '0;
    end else begin
      c_m[u] = c_m[u] + 1;
      idx    = (c_m[u] / p) % n;
      frames = c_m[u] / (n * p);
      phase  = (frames / BU[u]) % 2;
      lz     = lz_of(n, sh_dig[u], sh_dp[u]);
      vis    = sh_en[u][idx] && !(phase == 1 && sh_bl[u][idx]) && !lz[idx];
      if (vis) begin
        e.an  = mask & ~(16'd1 << idx);
        e.dig = sh_dig[u][4*idx +: 4];
        e.dp  = !sh_dp[u][idx];
      end
      e.fs = ((c_m[u] % (n * p)) == n * p - 1);
      if (e.fs) begin
        sh_dig[u] = dig_v[u];
        sh_en[u]  = en_v[u];
        sh_bl[u]  = bl_v[u];
        sh_dp[u]  = dp_v[u];
      end
    end
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_out(int u, exp_t e, logic [15:0] an, logic [3:0] dg, logic dp, logic fs);
    total++;
    if (an !== e.an || dg !== e.dig || dp !== e.dp || fs !== e.fs) begin
      bad++;
      $display("FAIL out u%0d cyc=%0d got AN=%h dig=%h dp=%b fs=%b exp AN=%h dig=%h dp=%b fs=%b",
               u, e.cyc, an, dg, dp, fs, e.an, e.dig, e.dp, e.fs);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc == tcyc) begin
      e = q0.pop_front();
      check_out(0, e, 16'(if0.AN), if0.dig_out, if0.dp_out, if0.frame_start);
    end
    if (q1.size() > 0 && q1[0].cyc == tcyc) begin
      e = q1.pop_front();
      check_out(1, e, 16'(if1.AN), if1.dig_out, if1.dp_out, if1.frame_start);
    end
  end

  task automatic rand_inputs(int u);
    for (int k = 0; k < 16; k++)
      dig_v[u][4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    en_v[u] = 16'($urandom | $urandom);
    bl_v[u] = 16'($urandom);
    dp_v[u] = 16'($urandom & $urandom & $urandom);
  endtask

  bit rand1_on = 1'b0;

  // Model the current cycle for both instances, then move to the next one.
  task automatic go();
    if (rand1_on) begin
      if ($urandom_range(0, 4) == 0) rand_inputs(1);
      rst_v[1] = ($urandom_range(0, 199) == 0);
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_idx0();
    return ((c_m[0] + 1) / PU[0]) % NU[0];
  endfunction

  int first_fs;

  initial begin
    rst_v    = 2'b11;
    c_m[0]   = -1;
    c_m[1]   = -1;
    dig_v[0] = 64'h4321;
    en_v[0]  = 16'h000F;
    bl_v[0]  = '0;
    dp_v[0]  = '0;
    rand_inputs(1);
    @(posedge clk);
    #1;
    repeat (3) go();
    rst_v    = 2'b00;
    rand1_on = 1'b1;

    first_fs = -1;
    for (int i = 0; i < 20 && first_fs < 0; i++) begin
      go();
      if (if0.frame_start === 1'b1) first_fs = c_m[0] + 1;
    end
    total++;
    if (first_fs != 8) begin
      bad++;
      $display("FAIL first_frame_start got=%0d exp=8", first_fs);
    end

    // Snapshot coherence: change digits mid-frame at slot 1.
    for (int i = 0; i < 20 && cur_idx0() != 1; i++) go();
    dig_v[0] = 64'h8765;
    repeat (24) go();

    // Enable, blink and decimal point.
    en_v[0] = 16'b1011;
    bl_v[0] = 16'b0001;
    dp_v[0] = 16'b0010;
    repeat (80) go();

    // Reset for one cycle while slot 2 is being scanned.
    en_v[0] = 16'h000F;
    bl_v[0] = '0;
    dp_v[0] = '0;
    for (int i = 0; i < 20 && cur_idx0() != 2; i++) go();
    rst_v[0] = 1'b1;
    go();
    rst_v[0] = 1'b0;
    repeat (30) go();

    // Leading-zero patterns.
    dig_v[0] = 64'h0050;
    repeat (20) go();
    dig_v[0] = 64'h0000;
    repeat (20) go();
    dig_v[0] = 64'h0050;
    dp_v[0]  = 16'b0100;
    repeat (20) go();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) rand_inputs(0);
      rst_v[0] = ($urandom_range(0, 119) == 0);
      go();
    end
    rst_v = 2'b00;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
